// File: rtl/pip_compositor.sv
// pip_compositor -- picture-in-picture frame compositor.
//
// Reads one background row and (for rows covered by the PIP) one PIP row from
// two show-ahead-less FIFOs (dout valid the cycle after rd_en), composites the
// row at one pixel per clock through a fixed 3-stage pipeline, then issues the
// row's burst write commands to the DRAM writer. Per-frame modes:
//   0 background only, 1 alpha blend, 2 chroma key, 3 opaque PIP.
//
// Build option: define PIP_COMPOSITOR_CHROMA_KEY_EN to enable chroma keying in
// MODE 2. When it is undefined MODE 2 is an alpha blend identical to MODE 1 and
// CHROMA_KEY / CHROMA_MASK are ignored.
//
// Ports:
//   CLK, RST_N           clock, asynchronous active-low reset
//   START                frame request (rising edge, honoured only when idle)
//   END, BUSY            end-of-frame pulse, frame-in-progress flag
//   PIP_X, PIP_Y         PIP top-left corner (clamped into the background)
//   ALPHA, MODE          PIP weight (255 = PIP only), composite mode
//   CHROMA_KEY/MASK      key colour and compare mask (chroma build only)
//   back_*, pip_*        FIFO data / pop / fill level for both streams
//   data_in, data_we     {strb, R, G, B, 8'hFF} pixel writes
//   ctrl_in, ctrl_we     {len, byte address} burst commands
module pip_compositor #(
  parameter int          BACK_WIDTH      = 1600,
  parameter int          BACK_HEIGHT     = 900,
  parameter int          PIP_WIDTH       = 640,
  parameter int          PIP_HEIGHT      = 480,
  parameter int          BURST_LEN       = 64,
  parameter logic [31:0] WRITE_BASE_ADDR = 32'h0,
  parameter int          CW              = 12
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  output logic          END,
  output logic          BUSY,
  input  logic [CW-1:0] PIP_X,
  input  logic [CW-1:0] PIP_Y,
  input  logic [7:0]    ALPHA,
  input  logic [1:0]    MODE,
  input  logic [23:0]   CHROMA_KEY,
  input  logic [23:0]   CHROMA_MASK,
  input  logic [31:0]   back_dout,
  output logic          back_rden,
  input  logic [CW-1:0] back_rdcnt,
  input  logic [31:0]   pip_dout,
  output logic          pip_rden,
  input  logic [CW-1:0] pip_rdcnt,
  output logic [35:0]   data_in,
  output logic          data_we,
  output logic [39:0]   ctrl_in,
  output logic          ctrl_we
);

  localparam logic [CW-1:0] BW     = CW'(BACK_WIDTH);
  localparam logic [CW-1:0] PW     = CW'(PIP_WIDTH);
  localparam logic [CW-1:0] PH     = CW'(PIP_HEIGHT);
  localparam logic [CW-1:0] X_LAST = CW'(BACK_WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(BACK_HEIGHT - 1);
  localparam logic [CW-1:0] X_MAX  = CW'(BACK_WIDTH - PIP_WIDTH);
  localparam logic [CW-1:0] Y_MAX  = CW'(BACK_HEIGHT - PIP_HEIGHT);
  localparam logic [CW-1:0] K_LAST = CW'(BACK_WIDTH / BURST_LEN - 1);
  localparam logic [7:0]    LEN    = 8'(BURST_LEN);
  localparam logic [31:0]   STEP   = 32'(BURST_LEN * 4);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ROW, S_STREAM, S_DRAIN, S_CMD, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]    start_hist_reg;
  logic [CW-1:0] pip_x_reg, pip_y_reg;
  logic [7:0]    alpha_reg;
  logic [1:0]    mode_reg;
  logic [CW-1:0] x_reg, y_reg, k_reg;
  logic [1:0]    drain_reg;
  logic [31:0]   addr_reg;

  logic start_edge, row_in_pip, in_win, fifo_ready;

  assign start_edge = start_hist_reg[0] & ~start_hist_reg[1];
  assign row_in_pip = (y_reg >= pip_y_reg) && (y_reg < pip_y_reg + PH);
  assign in_win     = row_in_pip && (x_reg >= pip_x_reg) && (x_reg < pip_x_reg + PW);
  assign fifo_ready = (back_rdcnt >= BW) && (!row_in_pip || (pip_rdcnt >= PW));

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    back_rden  = 1'b0;
    pip_rden   = 1'b0;
    ctrl_we    = 1'b0;
    ctrl_in    = 40'h0;
    BUSY       = 1'b0;
    END        = 1'b0;
    case (state_reg)
      S_IDLE:     if (start_edge) state_next = S_WAIT_ROW;
      S_WAIT_ROW: begin
        BUSY = 1'b1;
        if (fifo_ready) state_next = S_STREAM;
      end
      S_STREAM: begin
        BUSY      = 1'b1;
        back_rden = 1'b1;
        pip_rden  = in_win;   // popped in MODE 0 too, keeps the PIP stream aligned
        if (x_reg == X_LAST) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        BUSY = 1'b1;
        if (drain_reg == 2'd2) state_next = S_CMD;
      end
      S_CMD: begin
        BUSY    = 1'b1;
        ctrl_we = 1'b1;
        ctrl_in = {LEN, addr_reg};
        if (k_reg == K_LAST) state_next = (y_reg == Y_LAST) ? S_DONE : S_WAIT_ROW;
      end
      S_DONE: begin
        END        = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- control counters and latched configuration ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      start_hist_reg <= 2'b00;
      pip_x_reg      <= '0;
      pip_y_reg      <= '0;
      alpha_reg      <= 8'h0;
      mode_reg       <= 2'd0;
      x_reg          <= '0;
      y_reg          <= '0;
      k_reg          <= '0;
      drain_reg      <= 2'd0;
      addr_reg       <= 32'h0;
    end else begin
      start_hist_reg <= {start_hist_reg[0], START};
      case (state_reg)
        S_IDLE: if (start_edge) begin
          pip_x_reg <= (PIP_X > X_MAX) ? X_MAX : PIP_X;
          pip_y_reg <= (PIP_Y > Y_MAX) ? Y_MAX : PIP_Y;
          alpha_reg <= ALPHA;
          mode_reg  <= MODE;
          y_reg     <= '0;
          addr_reg  <= WRITE_BASE_ADDR;
        end
        S_WAIT_ROW: x_reg <= '0;
        S_STREAM: begin
          x_reg     <= x_reg + 1'b1;
          drain_reg <= 2'd0;
        end
        S_DRAIN: begin
          drain_reg <= drain_reg + 1'b1;
          k_reg     <= '0;
        end
        S_CMD: begin
          // Rows are contiguous in memory, so one running address covers
          // every burst of the frame; wraps modulo 2^32.
          k_reg    <= k_reg + 1'b1;
          addr_reg <= addr_reg + STEP;
          if (k_reg == K_LAST) y_reg <= y_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PIP_COMPOSITOR_CHROMA_KEY_EN
  logic [23:0] key_reg, mask_reg;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_reg  <= 24'h0;
      mask_reg <= 24'h0;
    end else if (state_reg == S_IDLE && start_edge) begin
      key_reg  <= CHROMA_KEY;
      mask_reg <= CHROMA_MASK;
    end
  end
`endif

  // ---------------- pixel pipeline ----------------
  // t: rden, t+1: FIFO data + stage-1 flags, t+2: products registered,
  // t+3: rounded pixel on data_in/data_we.
  logic        v1_reg, w1_reg, v2_reg, blend2_reg;
  logic [23:0] pix2_reg;
  logic [2:0][15:0] s2_reg;

  logic [23:0] back_rgb, pip_rgb, pix_sel, rgb_round;
  logic        blend_sel;
  logic [2:0][15:0] s_next, t_c, u_c;
  logic        unused_bits;

  assign back_rgb = back_dout[31:8];
  assign pip_rgb  = pip_dout[31:8];

`ifdef PIP_COMPOSITOR_CHROMA_KEY_EN
  logic key_match;
  assign key_match   = ((pip_rgb ^ key_reg) & mask_reg) == 24'h0;
  assign unused_bits = ^{back_dout[7:0], pip_dout[7:0]};
`else
  assign unused_bits = ^{back_dout[7:0], pip_dout[7:0], CHROMA_KEY, CHROMA_MASK};
`endif

  always_comb begin
    blend_sel = 1'b0;
    pix_sel   = back_rgb;
    if (w1_reg) begin
      case (mode_reg)
        2'd1: blend_sel = 1'b1;
`ifdef PIP_COMPOSITOR_CHROMA_KEY_EN
        2'd2: if (!key_match) pix_sel = pip_rgb;
`else
        2'd2: blend_sel = 1'b1;
`endif
        2'd3: pix_sel = pip_rgb;
        default: pix_sel = back_rgb;
      endcase
    end
  end

  // Per channel: s = p*A + b*(255-A) (max 65025), then the add-and-shift
  // below gives s/255 rounded to nearest without a divider.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign s_next[gi] = 16'(pip_rgb[8*gi +: 8]) * 16'(alpha_reg)
                        + 16'(back_rgb[8*gi +: 8]) * 16'(8'd255 - alpha_reg);
      assign t_c[gi] = s2_reg[gi] + 16'd128;
      assign u_c[gi] = t_c[gi] + {8'h00, t_c[gi][15:8]};
      assign rgb_round[8*gi +: 8] = 8'(u_c[gi] >> 8);
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v1_reg     <= 1'b0;
      w1_reg     <= 1'b0;
      v2_reg     <= 1'b0;
      blend2_reg <= 1'b0;
      pix2_reg   <= 24'h0;
      s2_reg     <= '0;
      data_we    <= 1'b0;
      data_in    <= 36'h0;
    end else begin
      v1_reg     <= back_rden;
      w1_reg     <= pip_rden;
      v2_reg     <= v1_reg;
      blend2_reg <= blend_sel;
      pix2_reg   <= pix_sel;
      s2_reg     <= s_next;
      data_we    <= v2_reg;
      if (v2_reg) data_in <= {4'hF, (blend2_reg ? rgb_round : pix2_reg), 8'hFF};
    end
  end

endmodule
